// File: rtl/wshb_stream_sink_pkg.sv
// Shared types and frame-geometry defaults for the video stream sink.
// Pure declarations; no logic, no latency, no backpressure.
// Consumers size their pixel counters from NPIX or their own overrides.
package video_pkg;

    localparam int unsigned HDISP_DFLT = 800;
    localparam int unsigned VDISP_DFLT = 480;
    localparam int unsigned NPIX       = HDISP_DFLT * VDISP_DFLT;

    typedef struct packed {
        logic        sof;
        logic [31:0] pix;
    } stream_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } sink_state_t;

endpackage

// File: rtl/wshb_stream_sink_if.sv
// Classic Wishbone bus bundle with master and slave views.
// No logic, no latency; ack/err/rty carry the slave's flow control.
// Data width follows DATA_BYTES; addresses are 32-bit byte addresses.
interface wshb_if #(
    parameter int DATA_BYTES = 4
) ();

    logic                      cyc;
    logic                      stb;
    logic                      we;
    logic [31:0]               adr;
    logic [8*DATA_BYTES-1:0]   dat_ms;
    logic [8*DATA_BYTES-1:0]   dat_sm;
    logic [DATA_BYTES-1:0]     sel;
    logic                      ack;
    logic                      err;
    logic                      rty;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel,
        output dat_sm, ack, err, rty
    );

endinterface

// File: rtl/wshb_stream_sink_fifo.sv
// Single-clock show-ahead FIFO; rdata is valid whenever not empty.
// Latency: a push is visible on rdata the cycle after its edge.
// Backpressure: push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_q[AW-1:0]];
    assign wr_d    = do_push ? wr_q + PW'(1) : wr_q;
    assign rd_d    = do_pop  ? rd_q + PW'(1) : rd_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/wshb_stream_sink.sv
// Terminates the pixel stream bus and replays each pixel as an SDRAM frame-buffer write.
// Latency: a pixel acked in cycle t is on the master bus from cycle t+2.
// Backpressure: slave ack withheld while the FIFO is full; master holds until ack or err.
module wshb_stream_sink
    import video_pkg::*;
#(
    parameter int unsigned HDISP      = HDISP_DFLT,
    parameter int unsigned VDISP      = VDISP_DFLT,
    parameter logic [31:0] FRAME_BASE = 32'h0,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic   sys_clk,
    input  logic   sys_rst,
    wshb_if.slave  wshb_ifs,
    wshb_if.master wshb_ifm,
    output logic   frame_done,
    output logic   err_flag
);

    localparam int unsigned NPIX_L = HDISP * VDISP;
    localparam int          IDX_W  = (NPIX_L > 1) ? $clog2(NPIX_L) : 1;

    stream_entry_t push_entry;
    stream_entry_t pop_entry;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          load;
    logic          done;
    logic [IDX_W-1:0] load_idx;

    sink_state_t state_q, state_d;
    logic        cyc_q, cyc_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic        last_q, last_d;
    logic        frame_done_q, frame_done_d;
    logic        err_flag_q, err_flag_d;

    // Slave side: writes go straight into the FIFO, reads are refused.
    assign push             = wshb_ifs.cyc & wshb_ifs.stb & wshb_ifs.we & ~fifo_full;
    assign wshb_ifs.ack     = push;
    assign wshb_ifs.err     = wshb_ifs.cyc & wshb_ifs.stb & ~wshb_ifs.we;
    assign wshb_ifs.rty     = 1'b0;
    assign wshb_ifs.dat_sm  = '0;
    assign push_entry.sof   = (wshb_ifs.adr == 32'h0);
    assign push_entry.pix   = wshb_ifs.dat_ms;

    sync_fifo #(
        .WIDTH ($bits(stream_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .push    (push),
        .pop     (pop),
        .wdata   (push_entry),
        .rdata   (pop_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign done     = (state_q == WRITE) & (wshb_ifm.ack | wshb_ifm.err);
    assign load_idx = pop_entry.sof ? '0 : idx_q;

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        idx_d        = idx_q;
        last_d       = last_q;
        frame_done_d = 1'b0;
        err_flag_d   = err_flag_q | (cyc_q & wshb_ifm.err);
        load         = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    load    = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (done) begin
                    frame_done_d = last_q;
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        cyc_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // idx_q always holds the index the next non-sof pixel will use.
        if (load) begin
            cyc_d  = 1'b1;
            adr_d  = FRAME_BASE + (32'(load_idx) << 2);
            dat_d  = pop_entry.pix;
            last_d = (load_idx == IDX_W'(NPIX_L - 1));
            idx_d  = last_d ? '0 : load_idx + IDX_W'(1);
        end
    end

    assign pop = load;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            cyc_q        <= 1'b0;
            adr_q        <= FRAME_BASE;
            dat_q        <= '0;
            idx_q        <= '0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            frame_done_q <= frame_done_d;
            err_flag_q   <= err_flag_d;
        end
    end

    assign wshb_ifm.cyc    = cyc_q;
    assign wshb_ifm.stb    = cyc_q;
    assign wshb_ifm.we     = cyc_q;
    assign wshb_ifm.adr    = adr_q;
    assign wshb_ifm.dat_ms = dat_q;
    assign wshb_ifm.sel    = 4'hF;
    assign frame_done      = frame_done_q;
    assign err_flag        = err_flag_q;

endmodule

// File: tb/tb_wshb_stream_sink.sv
// Directed bench for wshb_stream_sink with a 4x2 frame and a 16-entry FIFO.
module tb_wshb_stream_sink;

    localparam logic [31:0] FB = 32'h1000_0000;

    logic sys_clk = 1'b0;
    logic sys_rst;
    logic frame_done;
    logic err_flag;
    int   n_assert = 0;
    int   n_fail   = 0;

    wshb_if #(.DATA_BYTES(4)) s_if ();
    wshb_if #(.DATA_BYTES(4)) m_if ();

    wshb_stream_sink #(
        .HDISP      (4),
        .VDISP      (2),
        .FRAME_BASE (FB),
        .FIFO_DEPTH (16)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .wshb_ifs   (s_if),
        .wshb_ifm   (m_if),
        .frame_done (frame_done),
        .err_flag   (err_flag)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Every step leaves the bench 2 ns after a rising edge.
    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d, input string tag);
        s_if.cyc = 1'b1; s_if.stb = 1'b1; s_if.we = 1'b1;
        s_if.adr = a;    s_if.dat_ms = d;
        #1;
        for (int k = 0; k < 100 && !s_if.ack; k++) begin
            step();
            #1;
        end
        chk({tag, "_sack"}, 32'(s_if.ack), 32'd1);
        step();
        s_if.cyc = 1'b0; s_if.stb = 1'b0; s_if.we = 1'b0;
    endtask

    task automatic pixel(input logic [31:0] sa, input logic [31:0] sd, input logic [31:0] ea,
                         input logic use_err, input logic fd, input string tag);
        sw(sa, sd, tag);
        for (int k = 0; k < 20 && !m_if.stb; k++) step();
        chk({tag, "_stb"}, 32'(m_if.stb), 32'd1);
        chk({tag, "_adr"}, m_if.adr, ea);
        chk({tag, "_dat"}, m_if.dat_ms, sd);
        m_if.ack = ~use_err;
        m_if.err = use_err;
        step();
        m_if.ack = 1'b0;
        m_if.err = 1'b0;
        chk({tag, "_fdone"}, 32'(frame_done), 32'(fd));
        chk({tag, "_cyc_end"}, 32'(m_if.cyc), 32'd0);
    endtask

    initial begin
        sys_rst     = 1'b1;
        s_if.cyc    = 1'b0; s_if.stb = 1'b0; s_if.we = 1'b0;
        s_if.adr    = '0;   s_if.dat_ms = '0; s_if.sel = 4'hF;
        m_if.ack    = 1'b0; m_if.err = 1'b0; m_if.rty = 1'b0; m_if.dat_sm = '0;

        repeat (3) step();
        chk("rst_cyc",   32'(m_if.cyc), 32'd0);
        chk("rst_stb",   32'(m_if.stb), 32'd0);
        chk("rst_we",    32'(m_if.we),  32'd0);
        chk("rst_adr",   m_if.adr,      FB);
        chk("rst_dat",   m_if.dat_ms,   32'd0);
        chk("rst_sel",   32'(m_if.sel), 32'hF);
        chk("rst_fdone", 32'(frame_done), 32'd0);
        chk("rst_errf",  32'(err_flag),   32'd0);
        sys_rst = 1'b0;
        step();

        // Single write: same-cycle slave ack, master strobe two cycles later.
        s_if.cyc = 1'b1; s_if.stb = 1'b1; s_if.we = 1'b1;
        s_if.adr = 32'h0; s_if.dat_ms = 32'hDEAD_BEEF;
        #1;
        chk("t1_sack", 32'(s_if.ack), 32'd1);
        chk("t1_serr", 32'(s_if.err), 32'd0);
        step();
        s_if.cyc = 1'b0; s_if.stb = 1'b0; s_if.we = 1'b0;
        chk("t1_stb_t1", 32'(m_if.stb), 32'd0);
        step();
        chk("t1_stb_t2", 32'(m_if.stb), 32'd1);
        chk("t1_we",     32'(m_if.we),  32'd1);
        chk("t1_adr",    m_if.adr,      FB);
        chk("t1_dat",    m_if.dat_ms,   32'hDEAD_BEEF);
        chk("t1_sel",    32'(m_if.sel), 32'hF);
        m_if.ack = 1'b1;
        step();
        m_if.ack = 1'b0;
        chk("t1_cyc_drop", 32'(m_if.cyc), 32'd0);

        // Burst of 20 against a stalled SDRAM, then a continuous drain.
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    s_if.cyc = 1'b1; s_if.stb = 1'b1; s_if.we = 1'b1;
                    s_if.adr = (i == 0) ? 32'h0 : 32'(4 * i);
                    s_if.dat_ms = 32'hA000_0000 + 32'(i);
                    #1;
                    if (i < 16) chk($sformatf("burst_ack_early%0d", i), 32'(s_if.ack), 32'd1);
                    if (i == 17) chk("burst_ack_full", 32'(s_if.ack), 32'd0);
                    for (int k = 0; k < 200 && !s_if.ack; k++) begin
                        step();
                        #1;
                    end
                    chk($sformatf("burst_ack%0d", i), 32'(s_if.ack), 32'd1);
                    step();
                end
                s_if.cyc = 1'b0; s_if.stb = 1'b0; s_if.we = 1'b0;
            end
            begin
                repeat (30) step();
                m_if.ack = 1'b1;
                for (int j = 0; j < 20; j++) begin
                    if (j > 0) chk($sformatf("drain_cyc%0d", j), 32'(m_if.cyc), 32'd1);
                    for (int k = 0; k < 20 && !m_if.stb; k++) step();
                    chk($sformatf("drain_adr%0d", j), m_if.adr, FB + 32'(4 * (j % 8)));
                    chk($sformatf("drain_dat%0d", j), m_if.dat_ms, 32'hA000_0000 + 32'(j));
                    step();
                end
                m_if.ack = 1'b0;
                chk("drain_end_cyc", 32'(m_if.cyc), 32'd0);
            end
        join

        // Full 4x2 frame, then wrap on the ninth pixel.
        for (int i = 0; i < 8; i++) begin
            pixel((i == 0) ? 32'h0 : 32'(4 * i), 32'hF000_0000 + 32'(i), FB + 32'(4 * i),
                  1'b0, (i == 7), $sformatf("frame%0d", i));
        end
        pixel(32'd32, 32'hF000_0008, FB, 1'b0, 1'b0, "frame_wrap");

        // Resynchronisation on a mid-frame sof.
        pixel(32'h0, 32'hC000_0000, FB,        1'b0, 1'b0, "resync0");
        pixel(32'd4, 32'hC000_0001, FB + 32'd4, 1'b0, 1'b0, "resync1");
        pixel(32'd8, 32'hC000_0002, FB + 32'd8, 1'b0, 1'b0, "resync2");
        pixel(32'h0, 32'hC000_0003, FB,        1'b0, 1'b0, "resync3");

        // Read request on the stream side is refused.
        s_if.cyc = 1'b1; s_if.stb = 1'b1; s_if.we = 1'b0; s_if.adr = 32'd4;
        #1;
        chk("rd_serr",  32'(s_if.err), 32'd1);
        chk("rd_sack",  32'(s_if.ack), 32'd0);
        chk("rd_rty",   32'(s_if.rty), 32'd0);
        chk("rd_datsm", s_if.dat_sm,   32'd0);
        step();
        s_if.cyc = 1'b0; s_if.stb = 1'b0;
        repeat (3) step();
        chk("rd_no_master", 32'(m_if.cyc), 32'd0);

        // SDRAM error drops one pixel and latches err_flag.
        pixel(32'd4, 32'hE000_0001, FB + 32'd4, 1'b1, 1'b0, "err0");
        chk("err_flag_set", 32'(err_flag), 32'd1);
        pixel(32'd8, 32'hE000_0002, FB + 32'd8, 1'b0, 1'b0, "err1");
        chk("err_flag_sticky", 32'(err_flag), 32'd1);

        // Reset during a stalled write with a second entry queued.
        sw(32'd12, 32'h5555_0001, "mid0");
        sw(32'd16, 32'h5555_0002, "mid1");
        chk("mid_stb_before", 32'(m_if.stb), 32'd1);
        sys_rst = 1'b1;
        #1;
        chk("mid_cyc_async", 32'(m_if.cyc), 32'd0);
        chk("mid_stb_async", 32'(m_if.stb), 32'd0);
        chk("mid_errf_clr",  32'(err_flag), 32'd0);
        step();
        sys_rst = 1'b0;
        repeat (4) step();
        chk("mid_fifo_empty", 32'(m_if.cyc), 32'd0);
        pixel(32'd20, 32'h5555_0003, FB, 1'b0, 1'b0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
